// File: rtl/pb_debounce_if.sv
// Button bundle between the raw pads and the debouncer: raw levels in,
// clean levels, edge pulses and the shared sample tick out.
interface pb_debounce_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0] PB;
  logic [WIDTH-1:0] PB_CLEAN;
  logic [WIDTH-1:0] PB_RISE;
  logic [WIDTH-1:0] PB_FALL;
  logic             TICK;

  modport master (output PB, input PB_CLEAN, PB_RISE, PB_FALL, TICK);
  modport slave  (input PB, output PB_CLEAN, PB_RISE, PB_FALL, TICK);
endinterface

// File: rtl/pb_debounce.sv
// Push-button debouncer: 2-flop synchroniser, shared sample-tick prescaler,
// and one stability filter per button producing clean level and edge pulses.
module pb_debounce_lane #(
  parameter int STABLE_TICKS = 8
) (
  input  logic CLOCK,
  input  logic RESET_N,
  input  logic s2_i,
  input  logic tick_i,
  output logic clean_o,
  output logic rise_o,
  output logic fall_o
);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          clean_q, clean_d;
  logic          rise_q, rise_d;
  logic          fall_q, fall_d;

  // Any cycle where the input agrees with the accepted level restarts the
  // count, so only an uninterrupted run of mismatching ticks is accepted.
  always_comb begin
    cnt_d   = cnt_q;
    clean_d = clean_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (s2_i == clean_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d   = '0;
        clean_d = s2_i;
        rise_d  = s2_i;
        fall_d  = ~s2_i;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt_q   <= '0;
      clean_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign clean_o = clean_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
endmodule

module pb_debounce #(
  parameter int WIDTH        = 24,
  parameter int TICK_DIV     = 50000,
  parameter int STABLE_TICKS = 8
) (
  input  logic         CLOCK,
  input  logic         RESET_N,
  pb_debounce_if.slave bus
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic             tick_q, tick_d;
  logic [WIDTH-1:0] clean_w, rise_w, fall_w;

  // Tick is registered against the next prescaler value so it lines up with
  // pre == TICK_DIV-1 yet still reads 0 while held in reset.
  always_comb begin
    pre_d  = (pre_q == PRE_LAST) ? '0 : pre_q + PW'(1);
    tick_d = (pre_d == PRE_LAST);
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      s1_q   <= '0;
      s2_q   <= '0;
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      s1_q   <= bus.PB;
      s2_q   <= s1_q;
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    pb_debounce_lane #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_lane (
      .CLOCK  (CLOCK),
      .RESET_N(RESET_N),
      .s2_i   (s2_q[g]),
      .tick_i (tick_q),
      .clean_o(clean_w[g]),
      .rise_o (rise_w[g]),
      .fall_o (fall_w[g])
    );
  end

  assign bus.PB_CLEAN = clean_w;
  assign bus.PB_RISE  = rise_w;
  assign bus.PB_FALL  = fall_w;
  assign bus.TICK     = tick_q;
endmodule

// File: tb/tb_pb_debounce.sv
// Bench for pb_debounce: two configurations share one PB stimulus; a
// tick-run reference model feeds a per-cycle scoreboard, plus directed checks.
module tb_pb_debounce;
  localparam int W   = 24;
  localparam int TDA = 4;
  localparam int STA = 3;
  localparam int TDB = 1;
  localparam int STB = 1;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic [W-1:0] pb = '0;

  always #5 clk = ~clk;

  pb_debounce_if #(.WIDTH(W)) ifa ();
  pb_debounce_if #(.WIDTH(W)) ifb ();
  assign ifa.PB = pb;
  assign ifb.PB = pb;

  pb_debounce #(.WIDTH(W), .TICK_DIV(TDA), .STABLE_TICKS(STA)) dut_a (
    .CLOCK(clk), .RESET_N(rst_n), .bus(ifa));
  pb_debounce #(.WIDTH(W), .TICK_DIV(TDB), .STABLE_TICKS(STB)) dut_b (
    .CLOCK(clk), .RESET_N(rst_n), .bus(ifb));

  typedef struct packed {
    logic [W-1:0] clean;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         tick;
  } obs_t;
  typedef struct packed {
    obs_t a;
    obs_t b;
  } exp_t;

  exp_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: a bit flips once it has mismatched through st ticks
  // in a row; s2 is PB as sampled two edges earlier.
  int           td [2] = '{TDA, TDB};
  int           st [2] = '{STA, STB};
  logic [W-1:0] m_s1 [2];
  logic [W-1:0] m_s2 [2];
  logic [W-1:0] m_clean [2];
  logic [W-1:0] m_rise [2];
  logic [W-1:0] m_fall [2];
  int           m_n [2];
  int           m_run [2][W];

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = '0; m_s2[k] = '0; m_clean[k] = '0;
      m_rise[k] = '0; m_fall[k] = '0; m_n[k] = 0;
      for (int i = 0; i < W; i++) m_run[k][i] = 0;
    end
  endtask

  function automatic logic m_tick(input int k);
    return (m_n[k] > 0) && ((m_n[k] % td[k]) == td[k] - 1);
  endfunction

  task automatic model_step(input int k);
    logic tk;
    tk = m_tick(k);
    m_rise[k] = '0;
    m_fall[k] = '0;
    for (int i = 0; i < W; i++) begin
      if (m_s2[k][i] == m_clean[k][i]) m_run[k][i] = 0;
      else if (tk) begin
        m_run[k][i] = m_run[k][i] + 1;
        if (m_run[k][i] == st[k]) begin
          m_run[k][i]   = 0;
          m_clean[k][i] = m_s2[k][i];
          if (m_s2[k][i]) m_rise[k][i] = 1'b1;
          else            m_fall[k][i] = 1'b1;
        end
      end
    end
    m_s2[k] = m_s1[k];
    m_s1[k] = pb;
    m_n[k]  = m_n[k] + 1;
  endtask

  function automatic obs_t model_obs(input int k);
    obs_t o;
    o.clean = m_clean[k];
    o.rise  = m_rise[k];
    o.fall  = m_fall[k];
    o.tick  = m_tick(k);
    return o;
  endfunction

  initial model_reset();

  initial forever begin
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      model_step(0);
      model_step(1);
    end
    exp_q.push_back({model_obs(0), model_obs(1)});
  end

  // Asynchronous reset lands between edges: the pending expectation becomes all-zero.
  initial forever begin
    @(negedge rst_n);
    model_reset();
    if (exp_q.size() > 0) begin
      exp_q.delete();
      exp_q.push_back('0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_rng(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d..%0d t=%0t", name, act, lo, hi, $time);
    end
  endtask

  // Monitor: pop one expectation per cycle and tally DUT-A pulses per bit.
  int rise_cnt [W];
  int fall_cnt [W];
  int rise_cyc [W];
  int r_base [W];
  int f_base [W];
  int cyc = 0;

  initial begin
    for (int i = 0; i < W; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; rise_cyc[i] = -1;
    end
  end

  initial forever begin
    exp_t e;
    @(negedge clk);
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("a_clean", 32'(ifa.PB_CLEAN), 32'(e.a.clean));
      chk("a_rise",  32'(ifa.PB_RISE),  32'(e.a.rise));
      chk("a_fall",  32'(ifa.PB_FALL),  32'(e.a.fall));
      chk("a_tick",  32'(ifa.TICK),     32'(e.a.tick));
      chk("b_clean", 32'(ifb.PB_CLEAN), 32'(e.b.clean));
      chk("b_rise",  32'(ifb.PB_RISE),  32'(e.b.rise));
      chk("b_fall",  32'(ifb.PB_FALL),  32'(e.b.fall));
      chk("b_tick",  32'(ifb.TICK),     32'(e.b.tick));
      chk("a_rise_fall_excl", 32'(ifa.PB_RISE & ifa.PB_FALL), 32'd0);
    end
    for (int i = 0; i < W; i++) begin
      if (ifa.PB_RISE[i]) begin
        rise_cnt[i]++;
        rise_cyc[i] = cyc;
      end
      if (ifa.PB_FALL[i]) fall_cnt[i]++;
    end
  end

  task automatic snap();
    r_base = rise_cnt;
    f_base = fall_cnt;
  endtask

  function automatic int rd(input int i);
    return rise_cnt[i] - r_base[i];
  endfunction

  function automatic int fd(input int i);
    return fall_cnt[i] - f_base[i];
  endfunction

  function automatic int rsum_except(input logic [W-1:0] mask);
    int s = 0;
    for (int i = 0; i < W; i++) if (!mask[i]) s += rd(i);
    return s;
  endfunction

  function automatic int fsum_except(input logic [W-1:0] mask);
    int s = 0;
    for (int i = 0; i < W; i++) if (!mask[i]) s += fd(i);
    return s;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    // 1: buttons held through reset, then all accepted together
    pb = '1;
    idle(5);
    chk("rst_a_clean", 32'(ifa.PB_CLEAN), 32'd0);
    chk("rst_a_rise",  32'(ifa.PB_RISE),  32'd0);
    chk("rst_a_tick",  32'(ifa.TICK),     32'd0);
    chk("rst_b_tick",  32'(ifb.TICK),     32'd0);
    snap();
    rst_n = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (ifa.PB_CLEAN == '1) begin
        lat = k;
        break;
      end
    end
    chk_rng("t1_latency", lat, 11, 15);
    chk("t1_rise_all", 32'(ifa.PB_RISE), 32'hFF_FFFF);
    @(posedge clk); #1;
    chk("t1_rise_clear", 32'(ifa.PB_RISE), 32'd0);
    @(negedge clk);
    pb = '0;
    idle(30);
    chk("t1_all_released", 32'(ifa.PB_CLEAN), 32'd0);

    // 2: bounce on bit 0, then a stable press
    snap();
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) pb[0] = ~pb[0];
      @(negedge clk);
    end
    chk("t2_clean_during_bounce", 32'(ifa.PB_CLEAN[0]), 32'd0);
    pb[0] = 1'b1;
    idle(30);
    chk("t2_rise0_count", rd(0), 1);
    chk("t2_fall0_count", fd(0), 0);
    chk("t2_clean0", 32'(ifa.PB_CLEAN[0]), 32'd1);

    // 3: 5-cycle glitch on bit 5 is rejected
    snap();
    pb[5] = 1'b1;
    idle(5);
    pb[5] = 1'b0;
    idle(30);
    chk("t3_clean5", 32'(ifa.PB_CLEAN[5]), 32'd0);
    chk("t3_rise_total", rsum_except('0), 0);
    chk("t3_fall_total", fsum_except('0), 0);

    // 4: release of bit 7
    pb[7] = 1'b1;
    idle(30);
    chk("t4_clean7_high", 32'(ifa.PB_CLEAN[7]), 32'd1);
    snap();
    pb[7] = 1'b0;
    idle(30);
    chk("t4_fall7_count", fd(7), 1);
    chk("t4_rise_total", rsum_except('0), 0);
    chk("t4_clean7_low", 32'(ifa.PB_CLEAN[7]), 32'd0);

    // 5: bits 0 and 23 rise together; fast config follows s2 after one edge
    pb[0] = 1'b0;
    idle(30);
    snap();
    pb[0]  = 1'b1;
    pb[23] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (ifb.PB_CLEAN[0]) begin
        lat = k;
        break;
      end
    end
    chk("t5_fast_latency", lat, 3);
    idle(30);
    chk("t5_rise0", rd(0), 1);
    chk("t5_rise23", rd(23), 1);
    chk("t5_same_cycle", rise_cyc[0], rise_cyc[23]);
    chk("t5_other_rise", rsum_except(24'h80_0001), 0);
    chk("t5_any_fall", fsum_except('0), 0);

    // 6: reset mid-count on bit 3 with other bits clean-high
    pb[0]     = 1'b0;
    pb[23]    = 1'b0;
    pb[19:16] = 4'hF;
    idle(30);
    chk("t6_pre_clean", 32'(ifa.PB_CLEAN), 32'h0F_0000);
    snap();
    pb[3] = 1'b1;
    repeat (6) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_clean", 32'(ifa.PB_CLEAN), 32'd0);
    chk("t6_async_tick",  32'(ifa.TICK),     32'd0);
    chk("t6_async_b_clean", 32'(ifb.PB_CLEAN), 32'd0);
    #1 rst_n = 1'b1;
    idle(40);
    chk("t6_rise3", rd(3), 1);
    chk("t6_rise16", rd(16), 1);
    chk("t6_fall_total", fsum_except('0), 0);
    chk("t6_clean", 32'(ifa.PB_CLEAN), 32'h0F_0008);

    // Randomised soak against the scoreboard
    for (int k = 0; k < 600; k++) begin
      int b;
      @(negedge clk);
      if ($urandom_range(7) == 0) begin
        b = int'($urandom_range(W - 1));
        pb[b] = ~pb[b];
      end
      if ($urandom_range(2) == 0) pb[1] = ~pb[1];
    end
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
